run_controller: RTL and testbench

//  Hardware run sequencer placed directly upstream of the 9-bit processor top_level.

---
 rtl/run_controller.sv | 214 +++++++++++++++++++++
 tb/tb_run_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// run_controller: turns a go request into settle -> core_start pulse -> run with timeout, latching a pass/timeout verdict.
// Defining RUN_CTRL_DUMP_EN adds a post-run dump of the first DUMP_WORDS data-memory bytes.
module run_controller #(
   parameter int CNT_W      = 16,
   parameter int MAX_CYCLES = 1000,
   parameter int SETTLE_CYC = 2,
   parameter int DUMP_WORDS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   output logic             core_start,
   input  logic             core_done,
   output logic             busy,
   output logic             status_valid,
   output logic             passed,
   output logic             timed_out,
   output logic [CNT_W-1:0] cycle_count,
   output logic [7:0]       dmem_raddr,
   input  logic [7:0]       dmem_rdata,
   output logic             dump_valid,
   input  logic             dump_ready,
   output logic [7:0]       dump_addr,
   output logic [7:0]       dump_data
);

   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(MAX_CYCLES - 1);
   localparam logic [SET_W-1:0] SET_LOAD  = SET_W'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_START,
      S_RUN,
`ifdef RUN_CTRL_DUMP_EN
      S_DUMP,
`endif
      S_FINISH
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [SET_W-1:0] settle_cnt;
   logic             run_end;

`ifdef RUN_CTRL_DUMP_EN
   localparam logic [7:0] LAST_ADDR = 8'(DUMP_WORDS - 1);

   typedef enum logic [1:0] {
      D_ISSUE,
      D_CAPT,
      D_HOLD
   } dphase_t;

   dphase_t dphase;
   logic    dump_last;

   assign dump_last = (dphase == D_HOLD) && dump_ready && (dmem_raddr == LAST_ADDR);
`endif

   // Done has priority over the timeout check in the same cycle.
   assign run_end = core_done || (cycle_count == LAST_CNT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state   = state;
      core_start   = 1'b0;
      busy         = 1'b0;
      status_valid = 1'b0;
      case (state)
         S_IDLE: begin
            if (go) begin
               next_state = S_SETTLE;
            end
         end
         S_SETTLE: begin
            busy = 1'b1;
            if (settle_cnt == '0) begin
               next_state = S_START;
            end
         end
         S_START: begin
            busy       = 1'b1;
            core_start = 1'b1;
            next_state = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (run_end) begin
`ifdef RUN_CTRL_DUMP_EN
               next_state = S_DUMP;
`else
               next_state = S_FINISH;
`endif
            end
         end
`ifdef RUN_CTRL_DUMP_EN
         S_DUMP: begin
            busy = 1'b1;
            if (dump_last) begin
               next_state = S_FINISH;
            end
         end
`endif
         S_FINISH: begin
            status_valid = 1'b1;
            if (go) begin
               next_state = S_SETTLE;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         settle_cnt  <= '0;
         cycle_count <= '0;
         passed      <= 1'b0;
         timed_out   <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_FINISH: begin
               if (go) begin
                  settle_cnt  <= SET_LOAD;
                  cycle_count <= '0;
                  passed      <= 1'b0;
                  timed_out   <= 1'b0;
               end
            end
            S_SETTLE: begin
               if (settle_cnt != '0) begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            S_START: begin
               cycle_count <= '0;
            end
            S_RUN: begin
               // The cycle that observes done is not counted; the count saturates at LAST_CNT.
               if (core_done) begin
                  passed <= 1'b1;
               end else if (cycle_count == LAST_CNT) begin
                  timed_out <= 1'b1;
               end else begin
                  cycle_count <= cycle_count + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef RUN_CTRL_DUMP_EN
   // Each byte: address out, one cycle for the synchronous read, capture, hold until accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dphase     <= D_ISSUE;
         dmem_raddr <= '0;
         dump_valid <= 1'b0;
         dump_addr  <= '0;
         dump_data  <= '0;
      end else if (state == S_RUN) begin
         dphase     <= D_ISSUE;
         dmem_raddr <= '0;
         dump_valid <= 1'b0;
      end else if (state == S_DUMP) begin
         case (dphase)
            D_ISSUE: begin
               dphase <= D_CAPT;
            end
            D_CAPT: begin
               dump_data  <= dmem_rdata;
               dump_addr  <= dmem_raddr;
               dump_valid <= 1'b1;
               dphase     <= D_HOLD;
            end
            D_HOLD: begin
               if (dump_ready) begin
                  dump_valid <= 1'b0;
                  dphase     <= D_ISSUE;
                  if (dmem_raddr != LAST_ADDR) begin
                     dmem_raddr <= dmem_raddr + 1'b1;
                  end
               end
            end
            default: begin
               dphase <= D_ISSUE;
            end
         endcase
      end
   end
`else
   logic unused_dump;

   assign dmem_raddr  = '0;
   assign dump_valid  = 1'b0;
   assign dump_addr   = '0;
   assign dump_data   = '0;
   assign unused_dump = ^{dmem_rdata, dump_ready, 8'(DUMP_WORDS - 1)};
`endif

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: table of directed runs, randomized runs against a verdict model, reset and dump sequences.
module tb_run_controller;

   localparam int CNT_W      = 16;
   localparam int MAX_CYCLES = 1000;
   localparam int SETTLE_CYC = 2;
   localparam int DUMP_WORDS = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             go;
   logic             core_start;
   logic             core_done;
   logic             busy;
   logic             status_valid;
   logic             passed;
   logic             timed_out;
   logic [CNT_W-1:0] cycle_count;
   logic [7:0]       dmem_raddr;
   logic [7:0]       dmem_rdata;
   logic             dump_valid;
   logic             dump_ready;
   logic [7:0]       dump_addr;
   logic [7:0]       dump_data;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  mem [256];
   logic [15:0] dump_q [$];
   int          hold_err = 0;

   run_controller #(
      .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES), .SETTLE_CYC(SETTLE_CYC), .DUMP_WORDS(DUMP_WORDS)
   ) dut (
      .clk(clk), .reset(reset), .go(go), .core_start(core_start), .core_done(core_done),
      .busy(busy), .status_valid(status_valid), .passed(passed), .timed_out(timed_out),
      .cycle_count(cycle_count), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
      .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data)
   );

   always #5 clk = ~clk;

   // Synchronous-read data memory with one cycle of latency.
   always @(posedge clk) dmem_rdata <= mem[dmem_raddr];

   // Consumer: ready toggles every cycle; accepted bytes are logged and stalled bytes must hold.
   initial begin
      logic       prev_stall;
      logic [7:0] prev_addr, prev_data;
      prev_stall = 1'b0;
      prev_addr  = '0;
      prev_data  = '0;
      dump_ready = 1'b0;
      forever begin
         @(negedge clk);
         dump_ready = ~dump_ready;
         #1;
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && (!dump_valid || dump_addr != prev_addr || dump_data != prev_data))
               hold_err++;
            if (dump_valid && dump_ready) dump_q.push_back({dump_addr, dump_data});
            prev_stall = dump_valid && !dump_ready;
            prev_addr  = dump_addr;
            prev_data  = dump_data;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference verdict from the rules: d = counted RUN cycles before done (or never).
   task automatic model(input int d, output bit p, output bit t, output int cnt, output int len);
      if (d < MAX_CYCLES) begin
         p = 1'b1; t = 1'b0; cnt = d; len = d + 1;
      end else begin
         p = 1'b0; t = 1'b1; cnt = MAX_CYCLES - 1; len = MAX_CYCLES;
      end
   endtask

   // One run from IDLE/FINISH; done is raised during the RUN cycle whose count equals d.
   // noise: stale done through SETTLE/START and a go pulse mid-RUN, both to be ignored.
   task automatic run_once(input int d, input bit noise, output int gap, output int starts, output int run_len);
      int e;
      go        = 1'b1;
      core_done = noise;
      step();
      go = 1'b0;
      check("cleared_count", 32'(cycle_count), 0);
      check("cleared_verdict", {30'd0, passed, timed_out}, 0);
      check("busy_settle", 32'(busy), 1);
      e      = 1;
      starts = 0;
      gap    = -1;
      while (!core_start && e < 20) begin
         step();
         e++;
      end
      if (core_start) begin
         starts = 1;
         gap    = e - 1;
      end
      run_len = -1;
      for (int k = 0; k < 1300; k++) begin
         step();
         if (core_start) starts++;
         if (status_valid) begin
            run_len = k;
            break;
         end
         core_done = (k == d);
         go        = noise && (k == 3);
      end
      core_done = 1'b0;
      go        = 1'b0;
      if (run_len < 0) check("run_timeout_bound", 0, 1);
   endtask

   task automatic check_dump();
`ifdef RUN_CTRL_DUMP_EN
      check("dump_bytes", dump_q.size(), DUMP_WORDS);
      for (int i = 0; i < dump_q.size(); i++) check("dump_byte", 32'(dump_q[i]), 32'({8'(i), mem[i]}));
`endif
      dump_q.delete();
   endtask

   task automatic verify_run(input int d, input bit noise, input bit ep, input bit et, input int ec, input int el);
      int gap, starts, len;
      logic [CNT_W-1:0] held;
      run_once(d, noise, gap, starts, len);
      check("settle_gap", gap, SETTLE_CYC);
      check("start_pulses", starts, 1);
`ifndef RUN_CTRL_DUMP_EN
      check("run_length", len, el);
`endif
      check("passed", 32'(passed), 32'(ep));
      check("timed_out", 32'(timed_out), 32'(et));
      check("cycle_count", 32'(cycle_count), ec);
      check("status_valid", 32'(status_valid), 1);
      check("busy_finish", 32'(busy), 0);
      held = cycle_count;
      step();
      step();
      check("finish_hold", {30'd0, passed, timed_out, 16'd0} | 32'(cycle_count),
            {30'd0, ep, et, 16'd0} | 32'(held));
      check_dump();
   endtask

   typedef struct {
      int d;
      bit noise;
      bit exp_p;
      bit exp_t;
      int exp_cnt;
      int exp_len;
   } vec_t;

   initial begin
      vec_t tbl[6];
      bit   mp, mt;
      int   mc, ml, d, e, starts;

      for (int i = 0; i < 256; i++) mem[i] = 8'(i);

      tbl[0] = '{d: 37,   noise: 0, exp_p: 1, exp_t: 0, exp_cnt: 37,  exp_len: 38};
      tbl[1] = '{d: 5000, noise: 0, exp_p: 0, exp_t: 1, exp_cnt: 999, exp_len: 1000};
      tbl[2] = '{d: 999,  noise: 0, exp_p: 1, exp_t: 0, exp_cnt: 999, exp_len: 1000};
      tbl[3] = '{d: 0,    noise: 1, exp_p: 1, exp_t: 0, exp_cnt: 0,   exp_len: 1};
      tbl[4] = '{d: 998,  noise: 0, exp_p: 1, exp_t: 0, exp_cnt: 998, exp_len: 999};
      tbl[5] = '{d: 12,   noise: 1, exp_p: 1, exp_t: 0, exp_cnt: 12,  exp_len: 13};

      reset     = 1'b1;
      go        = 1'b0;
      core_done = 1'b0;
      #2;
      check("rst_outputs", {core_start, busy, status_valid, passed, timed_out, dump_valid}, 0);
      check("rst_count", 32'(cycle_count), 0);
      check("rst_dump", {dmem_raddr, dump_addr, dump_data}, 0);
      step();
      step();
      reset = 1'b0;
      step();
      check("idle_outputs", {core_start, busy, status_valid, passed, timed_out}, 0);

      foreach (tbl[i]) verify_run(tbl[i].d, tbl[i].noise, tbl[i].exp_p, tbl[i].exp_t, tbl[i].exp_cnt, tbl[i].exp_len);

      for (int r = 0; r < 6; r++) begin
         d = $urandom_range(0, 1100);
         model(d, mp, mt, mc, ml);
         verify_run(d, 1'($urandom_range(0, 1)), mp, mt, mc, ml);
      end

      // Asynchronous reset while RUN shows count 10.
      go = 1'b1;
      step();
      go = 1'b0;
      e  = 0;
      while (!(busy && !core_start && cycle_count == 10) && e < 50) begin
         step();
         e++;
      end
      check("reached_count10", 32'(cycle_count), 10);
      #2;
      reset = 1'b1;
      #1;
      check("midrun_rst_outputs", {core_start, busy, status_valid, passed, timed_out, dump_valid}, 0);
      check("midrun_rst_count", 32'(cycle_count), 0);
      step();
      reset  = 1'b0;
      starts = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (core_start || busy) starts++;
      end
      check("no_start_after_rst", starts, 0);
      dump_q.delete();
      verify_run(3, 0, 1, 0, 3, 4);

      check("dump_hold_errors", hold_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
